// File: rtl/fifo_rd_pack.sv
// Read-side packer for the cross-clock FIFO: pops PACK show-ahead words and
// presents them as one wide word on a registered valid/ready stream, with flush.
module fifo_rd_pack #(
    parameter int IN_WIDTH = 16,
    parameter int PACK     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fifo_nempty,
    input  logic [IN_WIDTH-1:0]      fifo_data,
    output logic                     fifo_re,
    input  logic                     flush,
    output logic                     flush_done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PACK*IN_WIDTH-1:0] out_data,
    output logic [3:0]               out_words
);

    localparam int         ACC_W = (PACK - 1) * IN_WIDTH;
    localparam logic [3:0] LAST  = 4'(PACK - 1);

    logic [ACC_W-1:0] acc;
    logic [3:0]       cnt;
    logic             flush_pend;
    logic             flush_ld_q;
    logic             out_free;
    logic             load_full;
    logic             load_flush;

    assign out_free   = ~out_valid | out_ready;
    // Gated by rst_n so the FIFO is never popped while this block is held in reset.
    assign fifo_re    = rst_n & fifo_nempty & ~flush_pend & ((cnt < LAST) | out_free);
    assign load_full  = fifo_re & (cnt == LAST);
    assign load_flush = flush_pend & (cnt != 4'd0) & out_free;

    // NOTE: acc is reset and cleared on every load because a partial word relies
    // on its unused high slots already being zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (load_full || load_flush) begin
            acc <= '0;
            cnt <= '0;
        end else if (fifo_re) begin
            for (int i = 0; i < PACK - 1; i++) begin
                if (cnt == 4'(i)) acc[i*IN_WIDTH +: IN_WIDTH] <= fifo_data;
            end
            cnt <= cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_words <= '0;
            out_valid <= 1'b0;
        end else if (load_full) begin
            out_data  <= {fifo_data, acc};
            out_words <= 4'(PACK);
            out_valid <= 1'b1;
        end else if (load_flush) begin
            out_data  <= {{IN_WIDTH{1'b0}}, acc};
            out_words <= cnt;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // A flush arriving while one is pending is absorbed into the pending one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_pend <= 1'b0;
            flush_ld_q <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            if (flush_pend && (load_flush || cnt == 4'd0)) flush_pend <= 1'b0;
            else if (flush)                                  flush_pend <= 1'b1;
            flush_ld_q <= load_flush;
            flush_done <= (flush_pend & (cnt == 4'd0)) | flush_ld_q;
        end
    end

endmodule

// File: tb/tb_fifo_rd_pack.sv
// Directed bench for fifo_rd_pack with a queue-based FIFO model and an
// output scoreboard of accepted words.
module tb_fifo_rd_pack;

    logic        clk;
    logic        rst_n;
    logic        fifo_nempty;
    logic [15:0] fifo_data;
    logic        fifo_re;
    logic        flush;
    logic        flush_done;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_words;

    fifo_rd_pack #(.IN_WIDTH(16), .PACK(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_nempty (fifo_nempty),
        .fifo_data   (fifo_data),
        .fifo_re     (fifo_re),
        .flush       (flush),
        .flush_done  (flush_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_words   (out_words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] q[$];
    logic [67:0] got[$];
    logic [15:0] sent[$];
    logic        gate;
    logic        last_re;
    int          checks;
    int          errors;
    int          viol;

    task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd();
        fifo_nempty = gate && (q.size() != 0);
        fifo_data   = (q.size() != 0) ? q[0] : 16'h0;
    endtask

    task automatic push(input logic [15:0] w);
        q.push_back(w);
        upd();
    endtask

    // Sample on the falling edge, apply the FIFO pop on the rising edge.
    task automatic step();
        @(negedge clk);
        last_re = fifo_re;
        if (fifo_re && !fifo_nempty) viol++;
        if (out_valid && out_ready) got.push_back({out_words, out_data});
        @(posedge clk);
        if (last_re) void'(q.pop_front());
        #1 upd();
        #1;
    endtask

    initial begin
        int pops;
        int n;
        checks = 0; errors = 0; viol = 0;
        gate = 1'b1; rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; last_re = 1'b0;
        upd();

        // Reset state with the FIFO already loaded.
        for (int i = 1; i <= 8; i++) push(16'(i));
        #2;
        check("rst_valid", 68'(out_valid), 68'd0);
        check("rst_data", 68'(out_data), 68'd0);
        check("rst_words", 68'(out_words), 68'd0);
        check("rst_done", 68'(flush_done), 68'd0);
        check("rst_re", 68'(fifo_re), 68'd0);
        step(); step();
        rst_n = 1'b1;
        #1;

        // Streaming with out_ready held high.
        for (int i = 0; i < 8; i++) begin
            check("t1_re_high", 68'(fifo_re), 68'd1);
            step();
            if (i == 2) check("t1_no_valid_yet", 68'(out_valid), 68'd0);
            if (i == 3) check("t1_word1", {3'b0, out_valid, out_words, out_data}, {4'd1, 4'd4, 64'h0004_0003_0002_0001});
            if (i == 7) check("t1_word2", {3'b0, out_valid, out_words, out_data}, {4'd1, 4'd4, 64'h0008_0007_0006_0005});
        end
        check("t1_re_empty", 68'(fifo_re), 68'd0);
        step();
        check("t1_drained", 68'(out_valid), 68'd0);
        check("t1_cnt", 68'(got.size()), 68'd2);
        check("t1_got0", got[0], {4'd4, 64'h0004_0003_0002_0001});
        check("t1_got1", got[1], {4'd4, 64'h0008_0007_0006_0005});

        // Backpressure: seven pops, then stall with the 8th word left in the FIFO.
        got.delete();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(16'(i));
        pops = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (last_re) pops++;
        end
        check("t2_pops", 68'(pops), 68'd7);
        check("t2_re_stall", 68'(fifo_re), 68'd0);
        check("t2_hold", {3'b0, out_valid, out_words, out_data}, {4'd1, 4'd4, 64'h0004_0003_0002_0001});
        out_ready = 1'b1;
        #1;
        check("t2_re_release", 68'(fifo_re), 68'd1);
        step();
        check("t2_no_gap", {3'b0, out_valid, out_words, out_data}, {4'd1, 4'd4, 64'h0008_0007_0006_0005});
        step();
        check("t2_drained", 68'(out_valid), 68'd0);
        check("t2_cnt", 68'(got.size()), 68'd2);
        check("t2_got0", got[0], {4'd4, 64'h0004_0003_0002_0001});
        check("t2_got1", got[1], {4'd4, 64'h0008_0007_0006_0005});

        // Flush of a two-word partial; no pops while the flush is pending.
        got.delete();
        push(16'h00AA); push(16'h00BB);
        step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        push(16'h00CC);
        #1;
        check("t3_re_blocked", 68'(fifo_re), 68'd0);
        step();
        check("t3_part", {3'b0, out_valid, out_words, out_data}, {4'd1, 4'd2, 64'h0000_0000_00BB_00AA});
        check("t3_done_early", 68'(flush_done), 68'd0);
        step();
        check("t3_done", 68'(flush_done), 68'd1);
        check("t3_cc_popped", 68'(q.size()), 68'd0);
        step();
        check("t3_done_pulse", 68'(flush_done), 68'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        check("t3_single", {3'b0, out_valid, out_words, out_data}, {4'd1, 4'd1, 64'h0000_0000_0000_00CC});
        step();
        check("t3_done2", 68'(flush_done), 68'd1);
        step();
        check("t3_cnt", 68'(got.size()), 68'd2);
        check("t3_got0", got[0], {4'd2, 64'h0000_0000_00BB_00AA});
        check("t3_got1", got[1], {4'd1, 64'h0000_0000_0000_00CC});

        // Empty flush, held two cycles so the second request is absorbed.
        got.delete();
        flush = 1'b1;
        step();
        check("t4_done_k", 68'(flush_done), 68'd0);
        step();
        flush = 1'b0;
        check("t4_done_k1", 68'(flush_done), 68'd1);
        check("t4_no_valid", 68'(out_valid), 68'd0);
        step();
        check("t4_done_k2", 68'(flush_done), 68'd0);
        step();
        check("t4_done_k3", 68'(flush_done), 68'd0);
        check("t4_no_words", 68'(got.size()), 68'd0);

        // Asynchronous reset mid-pack with cnt=2 and an output word stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(16'h0021 + 16'(i));
        for (int i = 0; i < 6; i++) step();
        check("t5_pre_valid", 68'(out_valid), 68'd1);
        rst_n = 1'b0;
        #1;
        check("t5_valid", 68'(out_valid), 68'd0);
        check("t5_data", 68'(out_data), 68'd0);
        check("t5_words", 68'(out_words), 68'd0);
        for (int i = 0; i < 4; i++) push(16'h0010 + 16'(i));
        #1;
        check("t5_re_in_rst", 68'(fifo_re), 68'd0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 4; i++) step();
        check("t5_restart", {3'b0, out_valid, out_words, out_data}, {4'd1, 4'd4, 64'h0013_0012_0011_0010});
        step();

        // Toggling nempty with random out_ready; scoreboard the packed stream.
        got.delete();
        sent.delete();
        viol = 0;
        for (int i = 0; i < 16; i++) begin
            sent.push_back(16'h0100 + 16'(i * 7));
            push(16'h0100 + 16'(i * 7));
        end
        n = 0;
        while (got.size() < 4 && n < 400) begin
            gate = ~gate;
            out_ready = 1'($urandom_range(0, 1));
            upd();
            step();
            n++;
        end
        gate = 1'b1;
        out_ready = 1'b1;
        upd();
        check("t6_viol", 68'(viol), 68'd0);
        check("t6_cnt", 68'(got.size()), 68'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size())
                check("t6_word", got[i], {4'd4, sent[4*i+3], sent[4*i+2], sent[4*i+1], sent[4*i]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
